vanilla_return_buffer: RTL and testbench

Buffers return packets from the tile endpoint and presents them one at a time to the vanilla core's network TX stage. It tracks the tile's outstanding remote-request credits and absorbs credit-only returns, so that stage never sees them. It raises a full indication, which obliges the core to consume the head packet in that same cycle. It sits between the endpoint's return output and the TX stage's `returned_*` inputs.

---
 rtl/vanilla_return_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_vanilla_return_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_return_buffer.sv
// vanilla_return_buffer
// Holds return packets from the tile endpoint and hands them one at a time to
// the core's network TX stage. Credit-only returns are absorbed here and only
// bump the outstanding-request credit counter. Full obliges the core to
// consume the head packet in the same cycle.
// Optional statistics counters: define VANILLA_RETURN_BUFFER_STATS_EN.
// Return packet types: 0 credit, 1 int_wb, 2 float_wb, 3 ifetch.
module vanilla_return_buffer
    #(parameter int data_width_p      = 32
    , parameter int reg_id_width_p    = 5
    , parameter int els_p             = 4
    , parameter int max_out_credits_p = 32
    , parameter bit full_yumi_check_p = 1'b1
    , localparam int pkt_type_width_lp = 2
    , localparam int credit_width_lp   = $clog2(max_out_credits_p + 1))
    (input  logic                         clk_i
    , input  logic                         reset_i
    , input  logic                         in_v_i
    , input  logic [data_width_p-1:0]      in_data_i
    , input  logic [reg_id_width_p-1:0]    in_reg_id_i
    , input  logic [pkt_type_width_lp-1:0] in_pkt_type_i
    , output logic                         in_ready_o
    , output logic                         returned_v_o
    , output logic [data_width_p-1:0]      returned_data_o
    , output logic [reg_id_width_p-1:0]    returned_reg_id_o
    , output logic [pkt_type_width_lp-1:0] returned_pkt_type_o
    , output logic                         returned_fifo_full_o
    , input  logic                         returned_yumi_i
    , input  logic                         out_req_v_i
    , output logic [credit_width_lp-1:0]   out_credits_o
    , output logic                         credit_avail_o
    , output logic                         credits_all_returned_o
    , output logic [31:0]                  stat_full_cycles_o
    , output logic [31:0]                  stat_returns_o
    );

    localparam logic [pkt_type_width_lp-1:0] e_return_credit_lp = 2'd0;

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p + 1);

    localparam logic [ptr_width_lp-1:0]    last_ptr_lp    = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0]  els_count_lp   = count_width_lp'(els_p);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    // Advance a ring pointer, wrapping at els_p (which need not be a power of two).
    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] ptr);
        if (ptr == last_ptr_lp) begin
            return ptr_width_lp'(0);
        end else begin
            return ptr + ptr_width_lp'(1);
        end
    endfunction

    logic [data_width_p-1:0]      data_mem_r   [els_p];
    logic [reg_id_width_p-1:0]    reg_id_mem_r [els_p];
    logic [pkt_type_width_lp-1:0] type_mem_r   [els_p];

    logic [ptr_width_lp-1:0]    wr_ptr_r;
    logic [ptr_width_lp-1:0]    rd_ptr_r;
    logic [count_width_lp-1:0]  count_r;
    logic [credit_width_lp-1:0] credits_r;
    logic [credit_width_lp-1:0] credits_next_s;

    logic full_s, valid_s, in_ready_s, accept_s, is_credit_s, enq_s, deq_s;

    // Handshake terms; ready depends only on registered occupancy, never on yumi.
    assign full_s      = (count_r == els_count_lp);
    assign valid_s     = (count_r != count_width_lp'(0));
    assign in_ready_s  = ~reset_i & ~full_s;
    assign accept_s    = in_v_i & in_ready_s;
    assign is_credit_s = (in_pkt_type_i == e_return_credit_lp);
    assign enq_s       = accept_s & ~is_credit_s;
    assign deq_s       = returned_yumi_i & valid_s;

    // Ring pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= ptr_width_lp'(0);
            rd_ptr_r <= ptr_width_lp'(0);
            count_r  <= count_width_lp'(0);
        end else begin
            wr_ptr_r <= enq_s ? next_ptr(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= deq_s ? next_ptr(rd_ptr_r) : rd_ptr_r;
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + count_width_lp'(1);
                2'b01:   count_r <= count_r - count_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Packet storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            data_mem_r[wr_ptr_r]   <= in_data_i;
            reg_id_mem_r[wr_ptr_r] <= in_reg_id_i;
            type_mem_r[wr_ptr_r]   <= in_pkt_type_i;
        end
    end

    // Credit counter next value: a launch takes one, any accepted return gives one.
    always_comb begin
        credits_next_s = credits_r;
        case ({out_req_v_i, accept_s})
            2'b10:   credits_next_s = credits_r - credit_width_lp'(1);
            2'b01:   credits_next_s = credits_r + credit_width_lp'(1);
            default: credits_next_s = credits_r;
        endcase
    end

    // Credit counter register, reloaded to the full allotment on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_r <= max_credits_lp;
        end else begin
            credits_r <= credits_next_s;
        end
    end

    assign in_ready_o             = in_ready_s;
    assign returned_v_o           = valid_s;
    assign returned_fifo_full_o   = full_s;
    assign returned_data_o        = data_mem_r[rd_ptr_r];
    assign returned_reg_id_o      = reg_id_mem_r[rd_ptr_r];
    assign returned_pkt_type_o    = type_mem_r[rd_ptr_r];
    assign out_credits_o          = credits_r;
    assign credit_avail_o         = (credits_r != credit_width_lp'(0));
    assign credits_all_returned_o = (credits_r == max_credits_lp);

`ifdef VANILLA_RETURN_BUFFER_STATS_EN
    logic [31:0] stat_full_cycles_r;
    logic [31:0] stat_returns_r;

    // Saturating counters of full cycles and enqueued data returns.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_full_cycles_r <= 32'd0;
            stat_returns_r     <= 32'd0;
        end else begin
            if (full_s && (stat_full_cycles_r != 32'hFFFF_FFFF)) begin
                stat_full_cycles_r <= stat_full_cycles_r + 32'd1;
            end else begin
                stat_full_cycles_r <= stat_full_cycles_r;
            end
            if (enq_s && (stat_returns_r != 32'hFFFF_FFFF)) begin
                stat_returns_r <= stat_returns_r + 32'd1;
            end else begin
                stat_returns_r <= stat_returns_r;
            end
        end
    end

    assign stat_full_cycles_o = stat_full_cycles_r;
    assign stat_returns_o     = stat_returns_r;
`else
    assign stat_full_cycles_o = 32'd0;
    assign stat_returns_o     = 32'd0;
`endif

    vanilla_return_buffer_checker
        #(.credit_width_p   (credit_width_lp)
        , .max_out_credits_p(max_out_credits_p)
        , .full_check_en_p  (full_yumi_check_p))
    checker_inst
        (.clk_i               (clk_i)
        , .reset_i             (reset_i)
        , .out_req_v_i         (out_req_v_i)
        , .credits_i           (credits_r)
        , .credit_inc_i        (accept_s & ~out_req_v_i)
        , .returned_yumi_i     (returned_yumi_i)
        , .returned_v_i        (valid_s)
        , .returned_fifo_full_i(full_s)
        );

endmodule

// Protocol checks on the core/endpoint side of the return buffer.
// full_check_en_p = 0 suits environments that are allowed to stall on full.
module vanilla_return_buffer_checker
    #(parameter int credit_width_p    = 6
    , parameter int max_out_credits_p = 32
    , parameter bit full_check_en_p   = 1'b1)
    (input  logic                      clk_i
    , input  logic                      reset_i
    , input  logic                      out_req_v_i
    , input  logic [credit_width_p-1:0] credits_i
    , input  logic                      credit_inc_i
    , input  logic                      returned_yumi_i
    , input  logic                      returned_v_i
    , input  logic                      returned_fifo_full_i
    );

    localparam logic [credit_width_p-1:0] max_lp = credit_width_p'(max_out_credits_p);

    a_no_req_without_credit: assert property (@(posedge clk_i) disable iff (reset_i)
        !(out_req_v_i && (credits_i == credit_width_p'(0))));

    a_no_credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(credit_inc_i && (credits_i == max_lp)));

    a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(returned_yumi_i && !returned_v_i));

    if (full_check_en_p) begin : g_full_check
        a_full_consumed: assert property (@(posedge clk_i) disable iff (reset_i)
            !(returned_fifo_full_i && returned_v_i && !returned_yumi_i));
    end

endmodule

// File: tb/tb_vanilla_return_buffer.sv
// Self-checking bench for vanilla_return_buffer against a queue-based model.
module tb_vanilla_return_buffer;

    localparam int MAXC = 32;
    localparam int ELS  = 4;
    localparam logic [1:0] T_CREDIT = 2'd0;
    localparam logic [1:0] T_INT    = 2'd1;
    localparam logic [1:0] T_FLOAT  = 2'd2;
    localparam logic [1:0] T_IFETCH = 2'd3;
`ifdef VANILLA_RETURN_BUFFER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  reg_id;
        logic [1:0]  ptype;
    } pkt_t;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        in_v_i = 1'b0;
    logic [31:0] in_data_i = 32'd0;
    logic [4:0]  in_reg_id_i = 5'd0;
    logic [1:0]  in_pkt_type_i = 2'd0;
    logic        in_ready_o;
    logic        returned_v_o;
    logic [31:0] returned_data_o;
    logic [4:0]  returned_reg_id_o;
    logic [1:0]  returned_pkt_type_o;
    logic        returned_fifo_full_o;
    logic        returned_yumi_i = 1'b0;
    logic        out_req_v_i = 1'b0;
    logic [5:0]  out_credits_o;
    logic        credit_avail_o;
    logic        credits_all_returned_o;
    logic [31:0] stat_full_cycles_o;
    logic [31:0] stat_returns_o;

    int checks = 0;
    int errors = 0;

    pkt_t m_q[$];
    int   m_credits = MAXC;
    int   m_stat_full = 0;
    int   m_stat_ret = 0;

    vanilla_return_buffer #(
        .data_width_p(32), .reg_id_width_p(5), .els_p(ELS),
        .max_out_credits_p(MAXC), .full_yumi_check_p(1'b0)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .in_v_i(in_v_i), .in_data_i(in_data_i), .in_reg_id_i(in_reg_id_i),
        .in_pkt_type_i(in_pkt_type_i), .in_ready_o(in_ready_o),
        .returned_v_o(returned_v_o), .returned_data_o(returned_data_o),
        .returned_reg_id_o(returned_reg_id_o), .returned_pkt_type_o(returned_pkt_type_o),
        .returned_fifo_full_o(returned_fifo_full_o), .returned_yumi_i(returned_yumi_i),
        .out_req_v_i(out_req_v_i), .out_credits_o(out_credits_o),
        .credit_avail_o(credit_avail_o), .credits_all_returned_o(credits_all_returned_o),
        .stat_full_cycles_o(stat_full_cycles_o), .stat_returns_o(stat_returns_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        in_v_i = 1'b0;
        returned_yumi_i = 1'b0;
        out_req_v_i = 1'b0;
        in_pkt_type_i = T_CREDIT;
    endtask

    // Apply the buffer's rules to the current inputs, then advance one clock edge.
    task automatic step();
        bit   acc;
        bit   enq;
        pkt_t p;
        if (reset_i) begin
            m_q.delete();
            m_credits = MAXC;
            m_stat_full = 0;
            m_stat_ret = 0;
        end else begin
            acc = in_v_i && (m_q.size() < ELS);
            enq = acc && (in_pkt_type_i != T_CREDIT);
            if (m_q.size() == ELS) m_stat_full++;
            if (enq) m_stat_ret++;
            if (returned_yumi_i && m_q.size() > 0) void'(m_q.pop_front());
            if (enq) begin
                p.data = in_data_i; p.reg_id = in_reg_id_i; p.ptype = in_pkt_type_i;
                m_q.push_back(p);
            end
            m_credits = m_credits - int'(out_req_v_i) + int'(acc);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_i = 1'b1;
        step(); step();
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_during: got %0b want 0", in_ready_o); end
        reset_i = 1'b0;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %0b want 1", in_ready_o); end
        checks++; if (returned_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %0b want 0", returned_v_o); end
        checks++; if (returned_fifo_full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", returned_fifo_full_o); end
        checks++; if (out_credits_o !== 6'd32) begin errors++; $display("FAIL reset_credits: got %0d want 32", out_credits_o); end
        checks++; if (credit_avail_o !== 1'b1) begin errors++; $display("FAIL reset_avail: got %0b want 1", credit_avail_o); end
        checks++; if (credits_all_returned_o !== 1'b1) begin errors++; $display("FAIL reset_all_ret: got %0b want 1", credits_all_returned_o); end
        checks++; if (stat_full_cycles_o !== 32'd0) begin errors++; $display("FAIL reset_stat_full: got %0d want 0", stat_full_cycles_o); end
        checks++; if (stat_returns_o !== 32'd0) begin errors++; $display("FAIL reset_stat_ret: got %0d want 0", stat_returns_o); end
    endtask

    task automatic test_credits();
        out_req_v_i = 1'b1;
        repeat (3) step();
        out_req_v_i = 1'b0;
        checks++; if (out_credits_o !== 6'd29) begin errors++; $display("FAIL credits_issue: got %0d want 29", out_credits_o); end
        checks++; if (credits_all_returned_o !== 1'b0) begin errors++; $display("FAIL credits_all_ret_low: got %0b want 0", credits_all_returned_o); end
        in_v_i = 1'b1;
        in_pkt_type_i = T_CREDIT;
        for (int i = 0; i < 3; i++) begin
            in_data_i = $urandom;
            step();
            checks++; if (returned_v_o !== 1'b0) begin errors++; $display("FAIL credits_no_enq: got v=%0b want 0 (i=%0d)", returned_v_o, i); end
        end
        drive_idle();
        checks++; if (out_credits_o !== 6'd32) begin errors++; $display("FAIL credits_return: got %0d want 32", out_credits_o); end
        checks++; if (credits_all_returned_o !== 1'b1) begin errors++; $display("FAIL credits_all_ret_high: got %0b want 1", credits_all_returned_o); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_data;
        out_req_v_i = 1'b1;
        repeat (4) step();
        out_req_v_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_v_i = 1'b1;
            in_pkt_type_i = T_INT;
            in_data_i = 32'hA + 32'(i);
            in_reg_id_i = 5'($urandom);
            step();
            checks++; if (returned_v_o !== 1'b1) begin errors++; $display("FAIL fill_v: got %0b want 1 (i=%0d)", returned_v_o, i); end
        end
        checks++; if (returned_fifo_full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b want 1", returned_fifo_full_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b want 0", in_ready_o); end
        in_data_i = 32'hDEAD_BEEF;
        repeat (5) step();
        in_v_i = 1'b0;
        checks++; if (stat_full_cycles_o !== (STATS_ON ? 32'd5 : 32'd0)) begin errors++; $display("FAIL stat_full: got %0d want %0d", stat_full_cycles_o, STATS_ON ? 5 : 0); end
        checks++; if (stat_returns_o !== (STATS_ON ? 32'd4 : 32'd0)) begin errors++; $display("FAIL stat_ret: got %0d want %0d", stat_returns_o, STATS_ON ? 4 : 0); end
        for (int i = 0; i < 4; i++) begin
            exp_data = 32'hA + 32'(i);
            checks++; if (returned_data_o !== exp_data) begin errors++; $display("FAIL drain_data: got %h want %h", returned_data_o, exp_data); end
            checks++; if (returned_reg_id_o !== m_q[0].reg_id) begin errors++; $display("FAIL drain_reg_id: got %0d want %0d", returned_reg_id_o, m_q[0].reg_id); end
            returned_yumi_i = 1'b1;
            if (i == 0) begin
                #1;
                checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL drain_no_comb_ready: got %0b want 0", in_ready_o); end
            end
            step();
            if (i == 0) begin
                checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready_next: got %0b want 1", in_ready_o); end
            end
        end
        drive_idle();
        checks++; if (returned_v_o !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0b want 0", returned_v_o); end
        checks++; if (out_credits_o !== 6'd32) begin errors++; $display("FAIL drain_credits: got %0d want 32", out_credits_o); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        logic [4:0]  r;
        out_req_v_i = 1'b1;
        for (int i = 0; i < 64 && m_credits > 10; i++) step();
        out_req_v_i = 1'b0;
        checks++; if (out_credits_o !== 6'd10) begin errors++; $display("FAIL simul_pre: got %0d want 10", out_credits_o); end
        d = $urandom; r = 5'($urandom);
        out_req_v_i = 1'b1; in_v_i = 1'b1; in_pkt_type_i = T_INT; in_data_i = d; in_reg_id_i = r;
        step();
        drive_idle();
        checks++; if (out_credits_o !== 6'd10) begin errors++; $display("FAIL simul_credits: got %0d want 10", out_credits_o); end
        checks++; if (returned_v_o !== 1'b1) begin errors++; $display("FAIL simul_v: got %0b want 1", returned_v_o); end
        checks++; if (returned_data_o !== d || returned_reg_id_o !== r || returned_pkt_type_o !== T_INT) begin
            errors++; $display("FAIL simul_head: got %h/%0d/%0d want %h/%0d/%0d", returned_data_o, returned_reg_id_o, returned_pkt_type_o, d, r, T_INT); end
        returned_yumi_i = 1'b1;
        step();
        drive_idle();
        checks++; if (returned_v_o !== 1'b0) begin errors++; $display("FAIL simul_drain: got %0b want 0", returned_v_o); end
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        logic [1:0]  exp_t;
        base = $urandom;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                exp_t = ((k - 1) % 2 == 0) ? T_IFETCH : T_FLOAT;
                checks++; if (returned_v_o !== 1'b1 || returned_data_o !== base + 32'(k - 1) || returned_pkt_type_o !== exp_t) begin
                    errors++; $display("FAIL wrap_head k=%0d: got v=%0b %h t=%0d want v=1 %h t=%0d", k, returned_v_o, returned_data_o, returned_pkt_type_o, base + 32'(k - 1), exp_t); end
            end
            in_v_i = (k < 10);
            in_pkt_type_i = (k % 2 == 0) ? T_IFETCH : T_FLOAT;
            in_data_i = base + 32'(k);
            in_reg_id_i = 5'(k);
            returned_yumi_i = (k > 0);
            step();
        end
        drive_idle();
        checks++; if (returned_v_o !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %0b want 0", returned_v_o); end
        checks++; if (out_credits_o !== 6'd20) begin errors++; $display("FAIL wrap_credits: got %0d want 20", out_credits_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            checks++; if (returned_v_o !== (m_q.size() > 0) || returned_fifo_full_o !== (m_q.size() == ELS) || in_ready_o !== (m_q.size() < ELS)) begin
                errors++; $display("FAIL rand_flags c=%0d: got v=%0b full=%0b rdy=%0b want size %0d", c, returned_v_o, returned_fifo_full_o, in_ready_o, m_q.size()); end
            checks++; if (out_credits_o !== m_credits[5:0] || credit_avail_o !== (m_credits != 0) || credits_all_returned_o !== (m_credits == MAXC)) begin
                errors++; $display("FAIL rand_credits c=%0d: got %0d avail=%0b all=%0b want %0d", c, out_credits_o, credit_avail_o, credits_all_returned_o, m_credits); end
            if (m_q.size() > 0) begin
                checks++; if (returned_data_o !== m_q[0].data || returned_reg_id_o !== m_q[0].reg_id || returned_pkt_type_o !== m_q[0].ptype) begin
                    errors++; $display("FAIL rand_head c=%0d: got %h/%0d/%0d want %h/%0d/%0d", c, returned_data_o, returned_reg_id_o, returned_pkt_type_o, m_q[0].data, m_q[0].reg_id, m_q[0].ptype); end
            end
            out_req_v_i = (m_credits > 0) && ($urandom_range(0, 1) == 0);
            returned_yumi_i = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            in_v_i = ($urandom_range(0, 1) == 1);
            in_pkt_type_i = 2'($urandom_range(0, 3));
            in_data_i = $urandom;
            in_reg_id_i = 5'($urandom);
            if (m_credits - int'(out_req_v_i) + 1 > MAXC) in_v_i = 1'b0;
            step();
        end
        drive_idle();
        checks++; if (stat_returns_o !== (STATS_ON ? 32'(m_stat_ret) : 32'd0) || stat_full_cycles_o !== (STATS_ON ? 32'(m_stat_full) : 32'd0)) begin
            errors++; $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", stat_returns_o, stat_full_cycles_o, STATS_ON ? m_stat_ret : 0, STATS_ON ? m_stat_full : 0); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16 && m_q.size() > 0; i++) begin
            returned_yumi_i = 1'b1;
            step();
        end
        drive_idle();
        for (int i = 0; i < 64 && m_credits != 23; i++) begin
            out_req_v_i = (m_credits > 23);
            in_v_i = (m_credits < 23);
            in_pkt_type_i = T_CREDIT;
            step();
        end
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            in_v_i = 1'b1; in_pkt_type_i = T_FLOAT; in_data_i = $urandom;
            step();
        end
        drive_idle();
        checks++; if (returned_v_o !== 1'b1 || out_credits_o !== 6'd25) begin errors++; $display("FAIL mid_pre: got v=%0b cr=%0d want v=1 cr=25", returned_v_o, out_credits_o); end
        reset_i = 1'b1; in_v_i = 1'b1; in_pkt_type_i = T_INT; out_req_v_i = 1'b1;
        step();
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready_during: got %0b want 0", in_ready_o); end
        step();
        reset_i = 1'b0;
        drive_idle();
        #1;
        checks++; if (returned_v_o !== 1'b0) begin errors++; $display("FAIL mid_v: got %0b want 0", returned_v_o); end
        checks++; if (out_credits_o !== 6'd32) begin errors++; $display("FAIL mid_credits: got %0d want 32", out_credits_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b want 1", in_ready_o); end
        checks++; if (stat_returns_o !== 32'd0 || stat_full_cycles_o !== 32'd0) begin errors++; $display("FAIL mid_stats: got %0d/%0d want 0/0", stat_returns_o, stat_full_cycles_o); end
    endtask

    initial begin
        test_reset();
        test_credits();
        test_fill_drain();
        test_simultaneous();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
